// File: rtl/bundle_pair_tx.sv
// bundle_pair_tx: packs a serial word stream into (bundle_out_0, bundle_out_1) pairs
// for a dual-bundle merge node. Odd-length packets get their last pair padded with
// PAD_VALUE. Completed pairs wait in a small circular FIFO behind a valid/ready handshake.
module bundle_pair_tx #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         bundle_out_0,
    output logic [WIDTH-1:0]         bundle_out_1,
    output logic                     out_padded,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              pair_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] mem_0 [DEPTH];
    logic [WIDTH-1:0] mem_1 [DEPTH];
    logic             mem_pad [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [15:0]      count;

    logic             full;
    logic             accept;
    logic             push;
    logic             pop;
    logic             load_hold;
    logic [WIDTH-1:0] push_0;
    logic [WIDTH-1:0] push_1;
    logic             push_pad;

    // Space check looks only at stored level, so a pop never frees a slot for a
    // push in the same cycle and out_ready has no path to in_ready.
    assign full      = (level == FULL_LEVEL);
    assign in_ready  = rst_n & ~full;
    assign accept    = in_valid & in_ready;
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;

    // Pairing FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EVEN;
        end else begin
            state <= next_state;
        end
    end

    // Decide per accepted word whether to hold it or complete (or pad) a pair.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        load_hold  = 1'b0;
        push_0     = in_data;
        push_1     = PAD_VALUE;
        push_pad   = 1'b0;
        if (accept) begin
            case (state)
                EVEN: begin
                    if (in_last) begin
                        push     = 1'b1;
                        push_pad = 1'b1;
                    end else begin
                        load_hold  = 1'b1;
                        next_state = ODD;
                    end
                end
                ODD: begin
                    push       = 1'b1;
                    push_0     = hold_reg;
                    push_1     = in_data;
                    next_state = EVEN;
                end
                default: next_state = EVEN;
            endcase
        end
    end

    // Even-position word waits here until its partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
        end else if (load_hold) begin
            hold_reg <= in_data;
        end
    end

    // Pair storage; contents are don't-care while unoccupied, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_0[wr_ptr]   <= push_0;
            mem_1[wr_ptr]   <= push_1;
            mem_pad[wr_ptr] <= push_pad;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Delivered-pair counter sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (pop && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    assign bundle_out_0 = out_valid ? mem_0[rd_ptr]   : '0;
    assign bundle_out_1 = out_valid ? mem_1[rd_ptr]   : '0;
    assign out_padded   = out_valid ? mem_pad[rd_ptr] : 1'b0;
    assign fifo_level   = level;
    assign pair_count   = count;

endmodule

// File: tb/tb_bundle_pair_tx.sv
// tb_bundle_pair_tx: directed self-checking bench for bundle_pair_tx.
module tb_bundle_pair_tx;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] PAD   = 32'h0;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  bundle_out_0;
    logic [WIDTH-1:0]  bundle_out_1;
    logic              out_padded;
    logic [2:0]        fifo_level;
    logic [15:0]       pair_count;

    int compareCount = 0;
    int failCount    = 0;

    bundle_pair_tx #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PAD_VALUE (PAD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .bundle_out_0 (bundle_out_0),
        .bundle_out_1 (bundle_out_1),
        .out_padded   (out_padded),
        .fifo_level   (fifo_level),
        .pair_count   (pair_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkPair(input string tag, input logic [31:0] b0, input logic [31:0] b1, input logic pad);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_b0"}, 64'(bundle_out_0), 64'(b0));
        checkOutput({tag, "_b1"}, 64'(bundle_out_1), 64'(b1));
        checkOutput({tag, "_pad"}, 64'(out_padded), 64'(pad));
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_level", 64'(fifo_level), 64'd0);
        checkOutput("rst_count", 64'(pair_count), 64'd0);
        checkOutput("rst_b0", 64'(bundle_out_0), 64'd0);
        checkOutput("rst_b1", 64'(bundle_out_1), 64'd0);
        checkOutput("rst_pad", 64'(out_padded), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] streaming A,B,C,D");
        applyStimulus(1'b1, 32'hA000_000A, 1'b0, 1'b1);
        tick();
        checkOutput("t1_hold_no_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'hB000_000B, 1'b0, 1'b1);
        tick();
        checkPair("t1_ab", 32'hA000_000A, 32'hB000_000B, 1'b0);
        checkOutput("t1_level_ab", 64'(fifo_level), 64'd1);
        applyStimulus(1'b1, 32'hC000_000C, 1'b0, 1'b1);
        tick();
        checkOutput("t1_after_pop_valid", 64'(out_valid), 64'd0);
        checkOutput("t1_count1", 64'(pair_count), 64'd1);
        applyStimulus(1'b1, 32'hD000_000D, 1'b0, 1'b1);
        tick();
        checkPair("t1_cd", 32'hC000_000C, 32'hD000_000D, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t1_count2", 64'(pair_count), 64'd2);
        checkOutput("t1_empty", 64'(out_valid), 64'd0);

        $display("[TB] single padded word");
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
        tick();
        checkPair("t2_pad", 32'h11, PAD, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t2_count3", 64'(pair_count), 64'd3);
        checkOutput("t2_empty_pad", 64'(out_padded), 64'd0);
        checkOutput("t2_empty_b0", 64'(bundle_out_0), 64'd0);

        $display("[TB] filling FIFO with out_ready low");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("t3_full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t3_full_level", 64'(fifo_level), 64'd4);
        applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("t3_wait_level", 64'(fifo_level), 64'd4);
        checkOutput("t3_wait_in_ready", 64'(in_ready), 64'd0);
        checkPair("t3_head_stable", 32'h100, 32'h101, 1'b0);

        $display("[TB] pop while full, then drain");
        applyStimulus(1'b1, 32'h108, 1'b0, 1'b1);
        tick();
        checkOutput("t4_pop_only_level", 64'(fifo_level), 64'd3);
        checkPair("t4_head1", 32'h102, 32'h103, 1'b0);
        checkOutput("t4_in_ready_open", 64'(in_ready), 64'd1);
        checkOutput("t4_count4", 64'(pair_count), 64'd4);
        tick();
        checkOutput("t4_level2", 64'(fifo_level), 64'd2);
        checkPair("t4_head2", 32'h104, 32'h105, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkPair("t4_head3", 32'h106, 32'h107, 1'b0);
        tick();
        checkOutput("t4_drained", 64'(out_valid), 64'd0);
        checkOutput("t4_count7", 64'(pair_count), 64'd7);
        applyStimulus(1'b1, 32'h109, 1'b0, 1'b0);
        tick();
        checkPair("t3_ninth_held", 32'h108, 32'h109, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        checkOutput("t4_refull_level", 64'(fifo_level), 64'd4);
        applyStimulus(1'b1, 32'h203, 1'b1, 1'b1);
        tick();
        checkOutput("t4_same_cycle_level", 64'(fifo_level), 64'd3);
        checkOutput("t4_count8", 64'(pair_count), 64'd8);
        applyStimulus(1'b1, 32'h203, 1'b1, 1'b0);
        tick();
        checkOutput("t4_next_cycle_push", 64'(fifo_level), 64'd4);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkPair("t4_drain", 32'h200 + 32'(i), PAD, 1'b1);
            tick();
        end
        checkOutput("t4_final_level", 64'(fifo_level), 64'd0);
        checkOutput("t4_count12", 64'(pair_count), 64'd12);

        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, 32'h31, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h32, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h34, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        checkOutput("t5_level2", 64'(fifo_level), 64'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("t5_rst_level", 64'(fifo_level), 64'd0);
        checkOutput("t5_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_rst_count", 64'(pair_count), 64'd0);
        checkOutput("t5_rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
        tick();
        checkPair("t5_fresh_pair", 32'h1, 32'h2, 1'b0);
        checkOutput("t5_level1", 64'(fifo_level), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t5_count1", 64'(pair_count), 64'd1);

        $display("[TB] pair_count saturation");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h600, 1'b1, 1'b1);
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t6_count_fffe", 64'(pair_count), 64'hFFFE);
        checkOutput("t6_level0", 64'(fifo_level), 64'd0);
        applyStimulus(1'b1, 32'h700, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("t6_count_sat", 64'(pair_count), 64'hFFFF);
        checkOutput("t6_final_level", 64'(fifo_level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
